// File: rtl/bcd_interval_timer_if.sv
// Control/status bundle for bcd_interval_timer; the key-pulse/control side is the master,
// the timer is the slave.
interface bcd_interval_timer_if #(
    parameter int DIGITS = 2
);
    localparam int W = 4 * DIGITS;

    logic         load;
    logic [W-1:0] preset_in;
    logic         mode_up;
    logic         start;
    logic         pause;
    logic         clear;
    logic [W-1:0] bcd_count;
    logic         running;
    logic         tick;
    logic         done;
    logic         done_pulse;

    modport master (
        output load, preset_in, mode_up, start, pause, clear,
        input  bcd_count, running, tick, done, done_pulse
    );

    modport slave (
        input  load, preset_in, mode_up, start, pause, clear,
        output bcd_count, running, tick, done, done_pulse
    );
endinterface

// File: rtl/bcd_interval_timer.sv
// N-digit BCD interval timer: programmable preset, up/down count, start/pause/clear, tick/done status.
// Define BCD_TIMER_AUTO_RELOAD_EN to restart each lap from the start value instead of stopping in DONE.
module bcd_interval_timer #(
    parameter int                  CLK_FREQ_HZ  = 12_000_000,
    parameter int                  TICK_HZ      = 1,
    parameter int                  DIGITS       = 2,
    parameter logic [4*DIGITS-1:0] RESET_PRESET = (4*DIGITS)'('h59)
) (
    input logic                 clk_in,
    input logic                 rst_n_in,
    bcd_interval_timer_if.slave bus
);
    localparam int            W       = 4 * DIGITS;
    localparam int            DIV     = CLK_FREQ_HZ / TICK_HZ;
    localparam int            PW      = $clog2(DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    localparam bit            AUTO_RELOAD = 1'b1;
`else
    localparam bit            AUTO_RELOAD = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++)
            if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
        return r;
    endfunction

    // One BCD step with ripple borrow/carry; each digit wraps 0<->9 independently.
    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (up) begin
                    if (v[4*k +: 4] == 4'd9) r[4*k +: 4] = 4'd0;
                    else begin
                        r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (v[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'd9;
                    else begin
                        r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  preset_q, preset_d;
    logic [PW-1:0] ps_q, ps_d;
    logic          dir_up_q, dir_up_d;
    logic          tick_q, tick_d;
    logic          pulse_q, pulse_d;
    logic          advance;
    logic [W-1:0]  next_count;

    logic [W-1:0] load_val, start_val, run_start, terminal, stepped;
    assign load_val  = bcd_clamp(bus.preset_in);
    assign start_val = bus.mode_up ? '0 : preset_q;
    assign run_start = dir_up_q ? '0 : preset_q;
    assign terminal  = dir_up_q ? preset_q : '0;
    assign stepped   = bcd_step(count_q, dir_up_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            count_q  <= RESET_PRESET;
            preset_q <= RESET_PRESET;
            ps_q     <= '0;
            dir_up_q <= 1'b0;
            tick_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            preset_q <= preset_d;
            ps_q     <= ps_d;
            dir_up_q <= dir_up_d;
            tick_q   <= tick_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        preset_d   = preset_q;
        ps_d       = ps_q;
        dir_up_d   = dir_up_q;
        tick_d     = 1'b0;
        pulse_d    = 1'b0;
        advance    = 1'b0;
        next_count = stepped;

        if (bus.load) begin
            preset_d = load_val;
            state_d  = S_IDLE;
            ps_d     = '0;
            count_d  = bus.mode_up ? '0 : load_val;
        end else if (bus.clear) begin
            state_d = S_IDLE;
            ps_d    = '0;
            count_d = start_val;
        end else if (bus.start) begin
            dir_up_d = bus.mode_up;
            ps_d     = '0;
            count_d  = start_val;
            if (!AUTO_RELOAD && preset_q == '0) begin
                state_d = S_DONE;
                pulse_d = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            // The resuming edge counts as a run cycle; the pausing edge does not.
            case (state_q)
                S_IDLE:  count_d = start_val;
                S_RUN:   if (bus.pause) state_d = S_PAUSE; else advance = 1'b1;
                S_PAUSE: if (bus.pause) begin
                             state_d = S_RUN;
                             advance = 1'b1;
                         end
                default: ;
            endcase
            if (advance) begin
                if (ps_q == PS_LAST) begin
                    ps_d   = '0;
                    tick_d = 1'b1;
                    if (AUTO_RELOAD && count_q == terminal) next_count = run_start;
                    count_d = next_count;
                    if (next_count == terminal) begin
                        pulse_d = 1'b1;
                        if (!AUTO_RELOAD) state_d = S_DONE;
                    end
                end else begin
                    ps_d = ps_q + PW'(1);
                end
            end
        end
    end

    assign bus.bcd_count  = count_q;
    assign bus.running    = (state_q == S_RUN);
    assign bus.tick       = tick_q;
    assign bus.done       = (state_q == S_DONE);
    assign bus.done_pulse = pulse_q;
endmodule
